// File: rtl/multi_product_vending_ctrl.sv
// Multi-product vending controller: per-slot price/stock tables, coin and
// online payment collection, dispense with change, refund and inactivity timeout.
module multi_product_vending_ctrl #(
  parameter int NUM_PRODUCTS   = 8,
  parameter int VALUE_W        = 8,
  parameter int STOCK_W        = 4,
  parameter int DEFAULT_PRICE  = 20,
  parameter int INIT_STOCK     = 5,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_cancel,
  input  logic               i_select,
  input  logic [3:0]         i_product_code,
  input  logic               i_coin_valid,
  input  logic [VALUE_W-1:0] i_coin_value,
  input  logic               i_online_payment,
  input  logic               i_cfg_we,
  input  logic [3:0]         i_cfg_idx,
  input  logic [VALUE_W-1:0] i_cfg_price,
  input  logic [STOCK_W-1:0] i_cfg_stock,
  output logic [2:0]         o_state,
  output logic [VALUE_W-1:0] o_credit,
  output logic [VALUE_W-1:0] o_product_price,
  output logic               o_dispense_valid,
  output logic [3:0]         o_dispense_code,
  output logic               o_change_valid,
  output logic [VALUE_W-1:0] o_return_change,
  output logic               o_error
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SELECT   = 3'd1;
  localparam logic [2:0] ST_COLLECT  = 3'd2;
  localparam logic [2:0] ST_DISPENSE = 3'd3;
  localparam logic [2:0] ST_REFUND   = 3'd4;

  localparam int         TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [4:0] NUM_LIMIT = 5'(NUM_PRODUCTS);

  logic [2:0]         state;
  logic [VALUE_W-1:0] credit;
  logic [VALUE_W-1:0] sel_price;
  logic [3:0]         sel_code;
  logic [TMR_W-1:0]   timer;

  // Tables span the full 4-bit code space; slots at or above NUM_PRODUCTS are never written.
  logic [VALUE_W-1:0] price_mem [16];
  logic [STOCK_W-1:0] stock_mem [16];

  logic [VALUE_W:0]   coin_sum;
  logic [VALUE_W-1:0] credit_add;
  logic               code_ok;
  logic               cfg_ok;
  logic               timed_out;

  always_comb begin
    coin_sum   = {1'b0, credit} + {1'b0, i_coin_value};
    credit_add = credit;
    if (i_coin_valid)
      credit_add = coin_sum[VALUE_W] ? {VALUE_W{1'b1}} : coin_sum[VALUE_W-1:0];
    code_ok   = ({1'b0, i_product_code} < NUM_LIMIT) && (stock_mem[i_product_code] != '0);
    cfg_ok    = ({1'b0, i_cfg_idx} < NUM_LIMIT);
    timed_out = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
  end

  assign o_state         = state;
  assign o_credit        = credit;
  assign o_product_price = (state == ST_COLLECT || state == ST_DISPENSE || state == ST_REFUND)
                           ? sel_price : '0;

  // Pulse outputs default low every cycle and are raised on the edge that enters the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= ST_IDLE;
      credit           <= '0;
      sel_price        <= '0;
      sel_code         <= '0;
      timer            <= '0;
      o_dispense_valid <= 1'b0;
      o_dispense_code  <= '0;
      o_change_valid   <= 1'b0;
      o_return_change  <= '0;
      o_error          <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        price_mem[i] <= VALUE_W'(DEFAULT_PRICE);
        stock_mem[i] <= STOCK_W'(INIT_STOCK);
      end
    end else begin
      o_dispense_valid <= 1'b0;
      o_dispense_code  <= '0;
      o_change_valid   <= 1'b0;
      o_return_change  <= '0;
      o_error          <= 1'b0;
      if (i_cfg_we && (state != ST_IDLE || !cfg_ok))
        o_error <= 1'b1;

      case (state)
        ST_IDLE: begin
          credit <= '0;
          timer  <= '0;
          if (i_cfg_we && cfg_ok) begin
            price_mem[i_cfg_idx] <= i_cfg_price;
            stock_mem[i_cfg_idx] <= i_cfg_stock;
          end
          if (i_start)
            state <= ST_SELECT;
        end

        ST_SELECT: begin
          if (i_cancel) begin
            state <= ST_IDLE;
            timer <= '0;
          end else if (i_select) begin
            timer <= '0;
            if (code_ok) begin
              state     <= ST_COLLECT;
              sel_code  <= i_product_code;
              sel_price <= price_mem[i_product_code];
            end else begin
              o_error <= 1'b1;
            end
          end else if (i_coin_valid) begin
            timer <= '0;
          end else if (timed_out) begin
            state <= ST_IDLE;
            timer <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        ST_COLLECT: begin
          credit <= credit_add;
          if (i_cancel) begin
            state           <= ST_REFUND;
            timer           <= '0;
            o_change_valid  <= 1'b1;
            o_return_change <= credit_add;
          end else if (i_online_payment || credit_add >= sel_price) begin
            state                <= ST_DISPENSE;
            timer                <= '0;
            o_dispense_valid     <= 1'b1;
            o_dispense_code      <= sel_code;
            o_change_valid       <= 1'b1;
            o_return_change      <= i_online_payment ? credit_add : credit_add - sel_price;
            stock_mem[sel_code]  <= stock_mem[sel_code] - STOCK_W'(1);
          end else if (i_coin_valid || i_select) begin
            timer <= '0;
          end else if (timed_out) begin
            state           <= ST_REFUND;
            timer           <= '0;
            o_change_valid  <= 1'b1;
            o_return_change <= credit;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        ST_DISPENSE, ST_REFUND: begin
          state  <= ST_IDLE;
          credit <= '0;
          timer  <= '0;
        end

        default: begin
          state  <= ST_IDLE;
          credit <= '0;
          timer  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_product_vending_ctrl.sv
// Directed self-checking bench for multi_product_vending_ctrl with default parameters.
module tb_multi_product_vending_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0, i_cancel = 1'b0, i_select = 1'b0;
  logic [3:0] i_product_code = '0;
  logic       i_coin_valid = 1'b0;
  logic [7:0] i_coin_value = '0;
  logic       i_online_payment = 1'b0;
  logic       i_cfg_we = 1'b0;
  logic [3:0] i_cfg_idx = '0;
  logic [7:0] i_cfg_price = '0;
  logic [3:0] i_cfg_stock = '0;
  logic [2:0] o_state;
  logic [7:0] o_credit, o_product_price, o_return_change;
  logic       o_dispense_valid, o_change_valid, o_error;
  logic [3:0] o_dispense_code;

  int total = 0;
  int bad   = 0;

  multi_product_vending_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_cancel(i_cancel),
    .i_select(i_select), .i_product_code(i_product_code),
    .i_coin_valid(i_coin_valid), .i_coin_value(i_coin_value),
    .i_online_payment(i_online_payment), .i_cfg_we(i_cfg_we), .i_cfg_idx(i_cfg_idx),
    .i_cfg_price(i_cfg_price), .i_cfg_stock(i_cfg_stock), .o_state(o_state),
    .o_credit(o_credit), .o_product_price(o_product_price),
    .o_dispense_valid(o_dispense_valid), .o_dispense_code(o_dispense_code),
    .o_change_valid(o_change_valid), .o_return_change(o_return_change), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock edge with the currently driven inputs, then strobes drop and outputs are settled.
  task automatic applyStimulus();
    @(posedge i_clk);
    #1;
    i_start = 1'b0; i_cancel = 1'b0; i_select = 1'b0; i_coin_valid = 1'b0;
    i_online_payment = 1'b0; i_cfg_we = 1'b0;
  endtask

  task automatic doStart();
    i_start = 1'b1; applyStimulus();
  endtask

  task automatic doSelect(input logic [3:0] code);
    i_select = 1'b1; i_product_code = code; applyStimulus();
  endtask

  task automatic doCoin(input logic [7:0] v);
    i_coin_valid = 1'b1; i_coin_value = v; applyStimulus();
  endtask

  task automatic doCfg(input logic [3:0] idx, input logic [7:0] price, input logic [3:0] stock);
    i_cfg_we = 1'b1; i_cfg_idx = idx; i_cfg_price = price; i_cfg_stock = stock; applyStimulus();
  endtask

  task automatic checkIdleQuiet(input string tag);
    checkOutput({tag, "_state"}, 32'(o_state), 0);
    checkOutput({tag, "_credit"}, 32'(o_credit), 0);
    checkOutput({tag, "_dv"}, 32'(o_dispense_valid), 0);
    checkOutput({tag, "_cv"}, 32'(o_change_valid), 0);
    checkOutput({tag, "_chg"}, 32'(o_return_change), 0);
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    checkIdleQuiet("rst");
    checkOutput("rst_price", 32'(o_product_price), 0);
    checkOutput("rst_err", 32'(o_error), 0);
    i_rst = 1'b0;
    applyStimulus();

    // Exact-credit purchase of slot 2 at default price 20
    doStart();
    checkOutput("t1_select", 32'(o_state), 1);
    doSelect(4'd2);
    checkOutput("t1_collect", 32'(o_state), 2);
    checkOutput("t1_price", 32'(o_product_price), 20);
    doCoin(8'd10);
    checkOutput("t1_credit10", 32'(o_credit), 10);
    checkOutput("t1_still_collect", 32'(o_state), 2);
    doCoin(8'd10);
    checkOutput("t1_dispense", 32'(o_state), 3);
    checkOutput("t1_dv", 32'(o_dispense_valid), 1);
    checkOutput("t1_code", 32'(o_dispense_code), 2);
    checkOutput("t1_cv", 32'(o_change_valid), 1);
    checkOutput("t1_chg", 32'(o_return_change), 0);
    checkOutput("t1_stock2", 32'(dut.stock_mem[2]), 4);
    applyStimulus();
    checkIdleQuiet("t1_end");

    // Reconfigured price 35: overpay by 5, then online payment returns all credit
    doCfg(4'd3, 8'd35, 4'd5);
    checkOutput("t2_cfg_err", 32'(o_error), 0);
    doStart();
    doSelect(4'd3);
    checkOutput("t2_price", 32'(o_product_price), 35);
    doCoin(8'd20);
    checkOutput("t2_state", 32'(o_state), 2);
    doCoin(8'd20);
    checkOutput("t2_dispense", 32'(o_state), 3);
    checkOutput("t2_chg", 32'(o_return_change), 5);
    applyStimulus();
    doStart();
    doSelect(4'd3);
    i_online_payment = 1'b1; doCoin(8'd10);
    checkOutput("t2_online_state", 32'(o_state), 3);
    checkOutput("t2_online_dv", 32'(o_dispense_valid), 1);
    checkOutput("t2_online_chg", 32'(o_return_change), 10);
    checkOutput("t2_online_credit", 32'(o_credit), 10);
    applyStimulus();

    // Cancel with a same-cycle coin refunds the full credit
    doStart();
    doSelect(4'd1);
    doCoin(8'd15);
    checkOutput("t3_credit", 32'(o_credit), 15);
    i_cancel = 1'b1; doCoin(8'd5);
    checkOutput("t3_refund", 32'(o_state), 4);
    checkOutput("t3_cv", 32'(o_change_valid), 1);
    checkOutput("t3_chg", 32'(o_return_change), 20);
    checkOutput("t3_dv", 32'(o_dispense_valid), 0);
    checkOutput("t3_stock1", 32'(dut.stock_mem[1]), 5);
    applyStimulus();
    checkIdleQuiet("t3_end");

    // Select errors: empty slot, out-of-range code; bad cfg index and cfg outside IDLE
    doCfg(4'd9, 8'd50, 4'd3);
    checkOutput("t4_cfg_bad_idx", 32'(o_error), 1);
    doCfg(4'd4, 8'd20, 4'd0);
    checkOutput("t4_cfg_ok", 32'(o_error), 0);
    doStart();
    doSelect(4'd4);
    checkOutput("t4_empty_err", 32'(o_error), 1);
    checkOutput("t4_empty_state", 32'(o_state), 1);
    applyStimulus();
    checkOutput("t4_err_pulse", 32'(o_error), 0);
    doSelect(4'd9);
    checkOutput("t4_range_err", 32'(o_error), 1);
    checkOutput("t4_range_state", 32'(o_state), 1);
    doCfg(4'd0, 8'd1, 4'd1);
    checkOutput("t4_cfg_busy_err", 32'(o_error), 1);
    doSelect(4'd0);
    checkOutput("t4_ok_state", 32'(o_state), 2);
    checkOutput("t4_ok_err", 32'(o_error), 0);
    checkOutput("t4_ok_price", 32'(o_product_price), 20);
    i_cancel = 1'b1; applyStimulus();
    checkOutput("t4_cancel_chg", 32'(o_return_change), 0);
    applyStimulus();
    doStart();
    i_cancel = 1'b1; applyStimulus();
    checkOutput("t4_sel_cancel", 32'(o_state), 0);
    checkOutput("t4_sel_cancel_cv", 32'(o_change_valid), 0);

    // Saturating credit against price 255
    doCfg(4'd5, 8'd255, 4'd5);
    doStart();
    doSelect(4'd5);
    doCoin(8'd200);
    checkOutput("t5_credit200", 32'(o_credit), 200);
    doCoin(8'd100);
    checkOutput("t5_sat_credit", 32'(o_credit), 255);
    checkOutput("t5_dispense", 32'(o_state), 3);
    checkOutput("t5_chg", 32'(o_return_change), 0);
    applyStimulus();

    // Inactivity timeout in COLLECT after 1000 idle cycles
    doStart();
    doSelect(4'd0);
    doCoin(8'd10);
    repeat (999) applyStimulus();
    checkOutput("t5_before_timeout", 32'(o_state), 2);
    applyStimulus();
    checkOutput("t5_timeout_state", 32'(o_state), 4);
    checkOutput("t5_timeout_cv", 32'(o_change_valid), 1);
    checkOutput("t5_timeout_chg", 32'(o_return_change), 10);
    applyStimulus();

    // Asynchronous reset mid-transaction restores tables and discards credit
    doStart();
    doSelect(4'd3);
    doCoin(8'd15);
    checkOutput("t6_credit", 32'(o_credit), 15);
    i_rst = 1'b1;
    #1;
    checkIdleQuiet("t6_async");
    applyStimulus();
    checkIdleQuiet("t6_held");
    i_rst = 1'b0;
    checkOutput("t6_stock2", 32'(dut.stock_mem[2]), 5);
    checkOutput("t6_stock4", 32'(dut.stock_mem[4]), 5);
    doStart();
    doSelect(4'd3);
    checkOutput("t6_price3", 32'(o_product_price), 20);
    doCoin(8'd20);
    checkOutput("t6_dispense", 32'(o_state), 3);
    checkOutput("t6_chg", 32'(o_return_change), 0);
    applyStimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_product_vending_ctrl.md
MULTI_PRODUCT_VENDING_CTRL -- requirements
Module: multi_product_vending_ctrl

Interface
REQ-001 SHALL have parameter NUM_PRODUCTS, default 8: number of product slots (2..16).
REQ-002 SHALL have parameter VALUE_W, default 8: width of every price, coin, credit and change value.
REQ-003 SHALL have parameter STOCK_W, default 4: width of each per-slot stock counter.
REQ-004 SHALL have parameter DEFAULT_PRICE, default 20: price loaded into every slot at reset.
REQ-005 SHALL have parameter INIT_STOCK, default 5: stock loaded into every slot at reset.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 1000: inactivity limit in SELECT/COLLECT.
REQ-007 SHALL have ports: i_clk  in  1  sole clock; i_rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have ports: i_start  in  1  begin transaction; i_cancel  in  1  abort transaction.
REQ-009 SHALL have ports: i_select  in  1  product strobe; i_product_code  in  4  slot index.
REQ-010 SHALL have ports: i_coin_valid  in  1  coin strobe; i_coin_value  in  VALUE_W  coin value.
REQ-011 SHALL have port: i_online_payment  in  1  online payment confirmed.
REQ-012 SHALL have ports: i_cfg_we  in  1  config write; i_cfg_idx  in  4  slot; i_cfg_price  in  VALUE_W; i_cfg_stock  in  STOCK_W.
REQ-013 SHALL have ports: o_state  out  3  state; o_credit  out  VALUE_W  accumulated credit; o_product_price  out  VALUE_W  selected price.
REQ-014 SHALL have ports: o_dispense_valid  out  1; o_dispense_code  out  4; o_change_valid  out  1; o_return_change  out  VALUE_W; o_error  out  1.

Function
REQ-015 States, encoding: IDLE=0, SELECT=1, COLLECT=2, DISPENSE=3, REFUND=4; unused codes SHALL go to IDLE next cycle.
REQ-016 IDLE: i_start -> SELECT; credit held at 0; i_cancel ignored.
REQ-017 Config write SHALL take effect only in IDLE and only for i_cfg_idx < NUM_PRODUCTS; otherwise dropped, o_error pulses 1 cycle.
REQ-018 SELECT: on i_select, valid code with stock != 0 -> COLLECT, latch code and price; invalid code or stock 0 -> o_error 1-cycle pulse, stay SELECT.
REQ-019 COLLECT: each i_coin_valid adds i_coin_value to credit, saturating at 2^VALUE_W-1.
REQ-020 COLLECT exit priority: i_cancel -> REFUND; else i_online_payment -> DISPENSE; else (credit incl. same-cycle coin) >= price -> DISPENSE.
REQ-021 A coin in the same cycle as cancel or online payment SHALL be added to credit before the transition.
REQ-022 DISPENSE: single cycle; o_dispense_valid=1, o_dispense_code=latched code; stock of slot decrements by 1; -> IDLE.
REQ-023 DISPENSE change: online paid -> o_return_change=credit; else credit-price; o_change_valid=1 same cycle, even if change is 0.
REQ-024 REFUND: single cycle; o_change_valid=1, o_return_change=credit; -> IDLE; credit cleared on entry to IDLE.
REQ-025 i_cancel in SELECT -> IDLE directly, no change pulse.
REQ-026 Timeout counter clears on state entry and on any i_select/i_coin_valid; reaching TIMEOUT_CYCLES: SELECT -> IDLE, COLLECT -> REFUND.
REQ-027 o_dispense_valid, o_change_valid, o_error SHALL be registered 1-cycle pulses; o_return_change SHALL be 0 when o_change_valid=0.
REQ-028 o_product_price SHALL show latched price in COLLECT/DISPENSE/REFUND, else 0.
REQ-029 Latency: qualifying input in cycle N -> state change and pulse outputs visible in cycle N+1.

Reset
REQ-030 i_rst SHALL asynchronously force IDLE, all outputs 0, credit 0, timeout counter 0, every price DEFAULT_PRICE, every stock INIT_STOCK.
REQ-031 Reset asserted mid-transaction SHALL discard credit without asserting o_change_valid or o_dispense_valid.

Verification
REQ-032 start, select code 2, coins 10+10 -> DISPENSE; dispense_valid=1, code=2, change_valid=1, return_change=0, slot 2 stock 5->4.
REQ-033 cfg slot 3 price 35; start, select 3, coins 20+20 -> return_change=5; then online path, coin 10 + online -> return_change=10.
REQ-034 start, select 1, coin 15, cancel with same-cycle coin 5 -> REFUND, return_change=20, no dispense, stock unchanged.
REQ-035 cfg slot 4 stock 0; select 4 -> o_error pulse, stay SELECT; select 9 -> o_error; select 0 -> COLLECT.
REQ-036 VALUE_W=8: coins 200+100 with price 255 -> credit saturates 255, dispense, change 0; idle 1000 cycles in COLLECT with credit 10 -> REFUND change 10.
REQ-037 assert i_rst during COLLECT with credit 15 -> o_state=0, o_credit=0, no pulses; prices/stocks restored to defaults.
